// File: rtl/multi_phase_traffic_ctrl.sv
// multi_phase_traffic_ctrl: N-phase round-robin traffic-light controller.
// Each phase runs GREEN -> YELLOW -> ALL-RED and then hands over to the next phase.
// Green and yellow lengths are set at runtime. Phases without demand can optionally be skipped.
// An emergency request pre-empts the running green and then holds its target phase green.
// All timing advances only on cycles where tick_en is high.
module multi_phase_traffic_ctrl #(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 8,
  parameter int ALLRED_TICKS = 1,
  parameter int SKIP_IDLE    = 0,
  localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_en,
  input  logic [CNT_W-1:0]        green_len,
  input  logic [CNT_W-1:0]        yellow_len,
  input  logic [NUM_PHASES-1:0]   phase_req,
  input  logic                    emg_req,
  input  logic [PH_W-1:0]         emg_phase,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PH_W-1:0]         cur_phase,
  output logic                    emg_active
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [PH_W-1:0]         cur_phase_q, cur_phase_d;
  logic [NUM_PHASES-1:0]   demand_q, demand_d;
  logic                    emg_active_q, emg_active_d;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;

  logic [PH_W-1:0]         rr_phase;
  logic [PH_W-1:0]         next_phase;
  logic [PH_W-1:0]         scan_idx;
  logic [PH_W-1:0]         target_phase;
  logic                    emg_valid;
  logic                    at_last;

  // A programmed length of zero behaves as a length of one tick
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  // Choose the phase that follows cur_phase: plain rotation, or the first phase with demand
  // (cur_phase itself is searched last) when skipping is enabled
  always_comb begin
    rr_phase   = (cur_phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : cur_phase_q + PH_W'(1);
    next_phase = rr_phase;
    scan_idx   = '0;
    if (SKIP_IDLE != 0) begin
      for (int k = NUM_PHASES; k >= 1; k--) begin
        scan_idx = PH_W'((int'(cur_phase_q) + k) % NUM_PHASES);
        if (demand_q[scan_idx]) next_phase = scan_idx;
      end
    end
  end

  // Next-state logic: len_q holds the length of the current state, so every state ends the same way
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    cur_phase_d  = cur_phase_q;
    demand_d     = demand_q | phase_req;
    emg_active_d = 1'b0;
    emg_valid    = emg_req && (int'(emg_phase) < NUM_PHASES);
    at_last      = (cnt_q == len_q - CNT_W'(1));
    target_phase = emg_valid ? emg_phase : next_phase;

    case (state_q)
      ST_ALLRED: begin
        if (tick_en && at_last) begin
          state_d               = ST_GREEN;
          cnt_d                 = '0;
          cur_phase_d           = target_phase;
          len_d                 = eff_len(green_len);
          demand_d[target_phase] = 1'b0;
        end else if (tick_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GREEN: begin
        if (emg_valid && (emg_phase != cur_phase_q)) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
          len_d   = eff_len(yellow_len);
        end else if (emg_valid) begin
          cnt_d        = '0;
          emg_active_d = 1'b1;
        end else if (emg_active_q) begin
          cnt_d = '0;
        end else if (tick_en && at_last) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
          len_d   = eff_len(yellow_len);
        end else if (tick_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (tick_en && at_last) begin
          state_d = ST_ALLRED;
          cnt_d   = '0;
          len_d   = CNT_W'(ALLRED_TICKS);
        end else if (tick_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ALLRED;
        cnt_d   = '0;
        len_d   = CNT_W'(ALLRED_TICKS);
      end
    endcase
  end

  // Decode the lamps from the upcoming state so the registered outputs change on the same edge
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      lights_d[3*i +: 3] = 3'b100;
      if (PH_W'(i) == cur_phase_d) begin
        if (state_d == ST_GREEN)  lights_d[3*i +: 3] = 3'b001;
        if (state_d == ST_YELLOW) lights_d[3*i +: 3] = 3'b010;
      end
    end
  end

  // State and output registers; reset drops every phase to red immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ALLRED;
      cnt_q        <= '0;
      len_q        <= CNT_W'(ALLRED_TICKS);
      cur_phase_q  <= PH_W'(NUM_PHASES - 1);
      demand_q     <= '0;
      emg_active_q <= 1'b0;
      lights_q     <= {NUM_PHASES{3'b100}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      cur_phase_q  <= cur_phase_d;
      demand_q     <= demand_d;
      emg_active_q <= emg_active_d;
      lights_q     <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign cur_phase  = cur_phase_q;
  assign emg_active = emg_active_q;

endmodule
